// File: rtl/charmap_pkg.sv
// charmap_pkg: shared constants for the character map.
//   - register offsets (HADDR[3:2] inside the register window)
//   - AHB HTRANS encodings
//   - clear engine state type
package charmap_pkg;

   localparam logic [1:0] REG_SCROLL = 2'd0;
   localparam logic [1:0] REG_CLEAR  = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } clr_state_e;

endpackage

// File: rtl/charmap_if.sv
// charmap_if: AHB-Lite slave-side signal bundle for the character map.
//   master modport: drives address/control/write data and HREADY
//   slave  modport: returns HREADYOUT and HRDATA
interface charmap_if;
   logic        HSEL;
   logic        HREADY;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      input  HREADYOUT, HRDATA
   );

   modport slave (
      input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      output HREADYOUT, HRDATA
   );
endinterface

// File: rtl/charmap_clear_engine.sv
// charmap_clear_engine: bulk-fill engine for the cell RAM.
//   start    in  : one-cycle pulse at the end of a CLEAR write (ignored while busy)
//   fill_val in  : value latched on start
//   busy     out : high for exactly CELLS cycles, starting the cycle after start
//   we/waddr/wdata out : RAM write port, one cell per busy cycle (0..CELLS-1)
module charmap_clear_engine
   import charmap_pkg::*;
#(
   parameter int CELLS  = 1200,
   parameter int CHAR_W = 8,
   parameter int AW     = 11
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              start,
   input  logic [CHAR_W-1:0] fill_val,
   output logic              busy,
   output logic              we,
   output logic [AW-1:0]     waddr,
   output logic [CHAR_W-1:0] wdata
);

   localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

   clr_state_e        state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [CHAR_W-1:0] val_q, val_d;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      busy    = 1'b0;
      we      = 1'b0;
      waddr   = cnt_q;
      wdata   = val_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               cnt_d   = '0;
               val_d   = fill_val;
            end
         end
         FILL: begin
            busy = 1'b1;
            we   = 1'b1;
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/charmap_mem.sv
// charmap_mem: AHB-Lite character map (COLS x ROWS cells of CHAR_W bits).
//   HCLK, HRESETn : clock, async active-low reset
//   ahb           : AHB-Lite slave (charmap_if.slave)
//                   HADDR[ADDR_W-1]=0 cell region, =1 registers at HADDR[3:2]:
//                   0 SCROLL, 1 CLEAR, 2 STATUS (bit0 busy), 3 reserved
//   disp_req/row/col in  : display lookup, one per cycle
//   disp_char/disp_vld out: cell value two cycles after disp_req
// Optional feature macro: CHARMAP_CLEAR_EN (bulk-clear engine). Without it,
// CLEAR is reserved, STATUS.busy reads 0 and HREADYOUT is constant 1.
module charmap_mem
   import charmap_pkg::*;
#(
   parameter  int COLS   = 40,
   parameter  int ROWS   = 30,
   parameter  int CHAR_W = 8,
   parameter  int ADDR_W = 14,
   localparam int RW     = $clog2(ROWS) + 1,
   localparam int CW     = $clog2(COLS) + 1
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   charmap_if.slave          ahb,
   input  logic              disp_req,
   input  logic [RW-1:0]     disp_row,
   input  logic [CW-1:0]     disp_col,
   output logic [CHAR_W-1:0] disp_char,
   output logic              disp_vld
);

   localparam int CELLS = COLS * ROWS;
   localparam int IDX_W = ADDR_W - 3;
   localparam int AW    = $clog2(CELLS);
   localparam logic [IDX_W:0] CELLS_I = (IDX_W + 1)'(CELLS);
   localparam logic [RW:0]    ROWS_S  = (RW + 1)'(ROWS);
   localparam logic [31:0]    ROWS_W  = ROWS;

   logic [CHAR_W-1:0] mem [CELLS];

   // address phase registers
   logic             act_q, act_d, wr_q, wr_d, reg_q, reg_d;
   logic [1:0]       roff_q, roff_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [RW-1:0]    scroll_q, scroll_d;
   // display pipeline
   logic [1:0]        vld_pipe_q, vld_pipe_d;
   logic [AW-1:0]     didx_q, didx_d;
   logic              oor_q, oor_d;
   logic [CHAR_W-1:0] disp_char_q, disp_char_d;

   logic              busy, cell_hit, in_range, hready, done, ahb_we;
   logic [AW-1:0]     cidx;
   logic [31:0]       rdata;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [CHAR_W-1:0] mem_wdata;
   logic [RW:0]       row_sum, phys_row;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         act_q       <= 1'b0;
         wr_q        <= 1'b0;
         reg_q       <= 1'b0;
         roff_q      <= '0;
         idx_q       <= '0;
         scroll_q    <= '0;
         vld_pipe_q  <= '0;
         didx_q      <= '0;
         oor_q       <= 1'b0;
         disp_char_q <= '0;
      end else begin
         act_q       <= act_d;
         wr_q        <= wr_d;
         reg_q       <= reg_d;
         roff_q      <= roff_d;
         idx_q       <= idx_d;
         scroll_q    <= scroll_d;
         vld_pipe_q  <= vld_pipe_d;
         didx_q      <= didx_d;
         oor_q       <= oor_d;
         disp_char_q <= disp_char_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Address phase: capture on HREADY, hold through a stalled data phase.
   always_comb begin
      act_d  = act_q;
      wr_d   = wr_q;
      reg_d  = reg_q;
      roff_d = roff_q;
      idx_d  = idx_q;
      if (ahb.HREADY) begin
         act_d  = ahb.HSEL && (ahb.HTRANS != HTRANS_IDLE);
         wr_d   = act_d && ahb.HWRITE;
         reg_d  = act_d && ahb.HADDR[ADDR_W-1];
         roff_d = act_d ? ahb.HADDR[3:2] : 2'b00;
         idx_d  = act_d ? ahb.HADDR[ADDR_W-2:2] : '0;
      end
   end

   assign cell_hit = act_q && !reg_q;
   assign in_range = {1'b0, idx_q} < CELLS_I;
   assign cidx     = idx_q[AW-1:0];
   // only cell-region accesses wait for the fill; register accesses never stall
   assign hready   = !(cell_hit && busy);
   assign done     = act_q && hready;
   assign ahb_we   = done && wr_q && cell_hit && in_range;

   always_comb begin
      scroll_d = scroll_q;
      if (done && wr_q && reg_q && roff_q == REG_SCROLL && ahb.HWDATA < ROWS_W)
         scroll_d = ahb.HWDATA[RW-1:0];
   end

   always_comb begin
      rdata = '0;
      if (act_q && !wr_q) begin
         if (!reg_q) begin
            if (in_range) rdata = 32'(mem[cidx]);
         end else begin
            case (roff_q)
               REG_SCROLL: rdata = 32'(scroll_q);
               REG_STATUS: rdata = {31'b0, busy};
               default:    rdata = '0;
            endcase
         end
      end
   end

   assign ahb.HREADYOUT = hready;
   assign ahb.HRDATA    = rdata;

`ifdef CHARMAP_CLEAR_EN
   logic              clr_start, eng_we;
   logic [AW-1:0]     eng_waddr;
   logic [CHAR_W-1:0] eng_wdata;

   assign clr_start = done && wr_q && reg_q && roff_q == REG_CLEAR;

   charmap_clear_engine #(.CELLS(CELLS), .CHAR_W(CHAR_W), .AW(AW)) u_clear (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .start    (clr_start),
      .fill_val (ahb.HWDATA[CHAR_W-1:0]),
      .busy     (busy),
      .we       (eng_we),
      .waddr    (eng_waddr),
      .wdata    (eng_wdata)
   );

   assign mem_we    = busy ? eng_we    : ahb_we;
   assign mem_waddr = busy ? eng_waddr : cidx;
   assign mem_wdata = busy ? eng_wdata : ahb.HWDATA[CHAR_W-1:0];
`else
   assign busy      = 1'b0;
   assign mem_we    = ahb_we;
   assign mem_waddr = cidx;
   assign mem_wdata = ahb.HWDATA[CHAR_W-1:0];
`endif

   // Display stage 1: scroll-wrapped row -> linear index. row < ROWS and
   // SCROLL < ROWS, so one conditional subtract is enough.
   assign row_sum  = {1'b0, disp_row} + {1'b0, scroll_q};
   assign phys_row = (row_sum >= ROWS_S) ? row_sum - ROWS_S : row_sum;

   always_comb begin
      vld_pipe_d  = {vld_pipe_q[0], disp_req};
      didx_d      = didx_q;
      oor_d       = oor_q;
      disp_char_d = disp_char_q;
      if (disp_req) begin
         oor_d  = (disp_row >= RW'(ROWS)) || (disp_col >= CW'(COLS));
         didx_d = oor_d ? '0 : AW'(disp_col) + AW'(COLS) * AW'(phys_row);
      end
      // stage 2: RAM read races the same-edge write, so the old value is returned
      if (vld_pipe_q[0])
         disp_char_d = oor_q ? '0 : mem[didx_q];
   end

   assign disp_char = disp_char_q;
   assign disp_vld  = vld_pipe_q[1];

   logic unused_bits;
   assign unused_bits = ^{ahb.HSIZE, ahb.HADDR[31:ADDR_W], ahb.HADDR[1:0], ahb.HWDATA};

endmodule

// File: tb/tb_charmap_mem.sv
module tb_charmap_mem;
   import charmap_pkg::*;

   localparam int COLS = 40, ROWS = 30, RW = 6, CW = 7, CELLS = COLS * ROWS;

   logic HCLK = 1'b0, HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   charmap_if bus();
   assign bus.HREADY = bus.HREADYOUT;

   logic          disp_req;
   logic [RW-1:0] disp_row;
   logic [CW-1:0] disp_col;
   logic [7:0]    disp_char;
   logic          disp_vld;

   charmap_mem dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .ahb       (bus),
      .disp_req  (disp_req),
      .disp_row  (disp_row),
      .disp_col  (disp_col),
      .disp_char (disp_char),
      .disp_vld  (disp_vld)
   );

   int n_cmp = 0, n_err = 0, cyc = 0;
   bit mon_en = 1'b0;
   logic [7:0] ref_mem [CELLS];
   int scroll_m = 0;

   typedef struct { logic [7:0] ch; int due; } dexp_t;
   dexp_t dq[$];
   logic [31:0] sb[$];

   typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; string name; } vec_t;
   vec_t vt[$];

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // display scoreboard: value and exact 2-cycle latency
   always @(negedge HCLK) begin
      if (mon_en && HRESETn && disp_vld) begin
         if (dq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL disp_unexpected: got vld char 0x%0h expected no output", disp_char);
         end else begin
            dexp_t e;
            e = dq.pop_front();
            check("disp_char", 32'(disp_char), 32'(e.ch));
            check("disp_latency", cyc, e.due);
         end
      end
   end

   function automatic logic [7:0] dexp(input int row, input int col);
      if (row >= ROWS || col >= COLS) return 8'h00;
      return ref_mem[col + COLS * ((row + scroll_m) % ROWS)];
   endfunction

   // call at #1 after an edge
   task automatic disp(input int row, input int col);
      dexp_t e;
      disp_req = 1'b1;
      disp_row = RW'(row);
      disp_col = CW'(col);
      e.ch = dexp(row, col);
      e.due = cyc + 2;
      dq.push_back(e);
   endtask

   task automatic disp_burst(input int rows[$], input int cols[$]);
      for (int i = 0; i < rows.size(); i++) begin
         @(posedge HCLK); #1;
         disp(rows[i], cols[i]);
      end
      @(posedge HCLK); #1;
      disp_req = 1'b0;
      repeat (3) @(posedge HCLK);
   endtask

   task automatic addr_phase(input logic wr, input logic [31:0] addr);
      bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HADDR = addr;
      bus.HWRITE = wr; bus.HSIZE = 3'b010;
   endtask

   task automatic bus_idle();
      bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE;
   endtask

   task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int stalls);
      @(posedge HCLK); #1;
      addr_phase(wr, addr);
      @(posedge HCLK); #1;
      bus_idle();
      bus.HWDATA = wdata;
      stalls = 0;
      while (!bus.HREADYOUT && stalls < 2000) begin
         @(posedge HCLK); #1;
         stalls++;
      end
      rdata = bus.HRDATA;
   endtask

   task automatic ahb_read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      int st;
      sb.push_back(exp);
      ahb_xfer(1'b0, addr, 32'h0, rd, st);
      check(name, rd, sb.pop_front());
   endtask

   task automatic add(input bit wr, input logic [31:0] addr, input logic [31:0] data, input string name);
      vec_t v;
      v.wr = wr; v.addr = addr; v.data = data; v.name = name;
      vt.push_back(v);
   endtask

`ifdef CHARMAP_CLEAR_EN
   // CLEAR write followed by back-to-back STATUS reads; counts busy data phases
   task automatic clear_poll(input logic [31:0] val, output int nbusy, output logic first, output logic last);
      @(posedge HCLK); #1;
      addr_phase(1'b1, 32'h2004);
      @(posedge HCLK); #1;
      bus.HWDATA = val;
      addr_phase(1'b0, 32'h2008);
      nbusy = 0; first = 1'b0; last = 1'b0;
      for (int i = 0; i < 1300; i++) begin
         @(posedge HCLK); #1;
         if (i == 0) first = bus.HRDATA[0];
         if (bus.HRDATA[0]) nbusy++;
         last = bus.HRDATA[0];
      end
      bus_idle();
   endtask
`endif

   initial begin
      logic [31:0] rd;
      int st, nb;
      logic first, last;

      bus_idle();
      bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010; bus.HWDATA = '0;
      disp_req = 1'b0; disp_row = '0; disp_col = '0;
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_hrdata", bus.HRDATA, 32'h0);
      check("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
      check("rst_disp_char", 32'(disp_char), 32'h0);
      check("rst_disp_vld", 32'(disp_vld), 32'h0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      mon_en = 1'b1;

      // table-driven AHB vectors; read data is the expected value
      add(1, 32'h0154, 32'h41,  "w_r2c5");   add(0, 32'h0154, 32'h41, "r_r2c5");
      add(1, 32'h0158, 32'h1C3, "w_trunc");  add(0, 32'h0158, 32'hC3, "r_trunc");
      add(1, 32'h0000, 32'hAB,  "w_cell0");  add(0, 32'h0000, 32'hAB, "r_cell0");
      add(1, 32'h00A0, 32'h5A,  "w_cell40"); add(0, 32'h00A0, 32'h5A, "r_cell40");
      add(1, 32'h12BC, 32'h7E,  "w_last");   add(0, 32'h12BC, 32'h7E, "r_last");
      add(1, 32'h1300, 32'h55,  "w_oob");    add(0, 32'h1300, 32'h0,  "r_oob");
      add(0, 32'h1FFC, 32'h0,   "r_oob_top");
      add(0, 32'h2000, 32'h0,   "r_scroll_rst");
      add(1, 32'h2000, 32'd29,  "w_scroll29"); add(0, 32'h2000, 32'd29, "r_scroll29");
      add(1, 32'h2000, 32'd30,  "w_scroll30"); add(0, 32'h2000, 32'd29, "r_scroll_ign");
      add(1, 32'h2000, 32'd3,   "w_scroll3");  add(0, 32'h2000, 32'd3,  "r_scroll3");
      add(0, 32'h2008, 32'h0,   "r_status");
      add(0, 32'h200C, 32'h0,   "r_rsvd");

      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].wr) begin
            ahb_xfer(1'b1, vt[i].addr, vt[i].data, rd, st);
            if (!vt[i].addr[13] && (vt[i].addr[12:2] < CELLS))
               ref_mem[vt[i].addr[12:2]] = vt[i].data[7:0];
            if (vt[i].addr == 32'h2000 && vt[i].data < ROWS)
               scroll_m = int'(vt[i].data);
         end else begin
            ahb_read_chk(vt[i].name, vt[i].addr, vt[i].data);
         end
      end

      // display with SCROLL=3, including out-of-range coordinates
      disp_burst('{28, 26, 27, 30, 0, 63}, '{0, 39, 0, 0, 40, 127});
      ahb_xfer(1'b1, 32'h2000, 32'd0, rd, st);
      scroll_m = 0;
      disp_burst('{2, 2, 29, 1, 0}, '{5, 6, 39, 0, 0});

      // AHB write and display read of the same cell on the same edge -> old value
      @(posedge HCLK); #1;
      addr_phase(1'b1, 32'h0000);
      disp(0, 0);
      @(posedge HCLK); #1;
      bus_idle();
      bus.HWDATA = 32'h99;
      disp_req = 1'b0;
      @(posedge HCLK); #1;
      ref_mem[0] = 8'h99;
      disp_burst('{0}, '{0});
      ahb_read_chk("r_after_rbw", 32'h0000, 32'h99);

      // SCROLL write and display request together -> old SCROLL used
      @(posedge HCLK); #1;
      addr_phase(1'b1, 32'h2000);
      @(posedge HCLK); #1;
      bus_idle();
      bus.HWDATA = 32'd29;
      disp(1, 0);
      @(posedge HCLK); #1;
      scroll_m = 29;
      disp(1, 0);
      @(posedge HCLK); #1;
      disp_req = 1'b0;
      repeat (3) @(posedge HCLK);
      ahb_xfer(1'b1, 32'h2000, 32'd0, rd, st);
      scroll_m = 0;

`ifdef CHARMAP_CLEAR_EN
      clear_poll(32'h20, nb, first, last);
      check("clr_busy_first", 32'(first), 32'h1);
      check("clr_busy_cycles", nb, 1200);
      check("clr_busy_last", 32'(last), 32'h0);
      for (int i = 0; i < CELLS; i++) ref_mem[i] = 8'h20;
      for (int i = 0; i < CELLS; i++) ahb_read_chk("clr_cell", 32'(i * 4), 32'h20);

      // cell read pipelined right behind CLEAR stalls for the whole fill
      @(posedge HCLK); #1;
      addr_phase(1'b1, 32'h2004);
      @(posedge HCLK); #1;
      bus.HWDATA = 32'h33;
      addr_phase(1'b0, 32'h0154);
      @(posedge HCLK); #1;
      bus_idle();
      st = 0;
      while (!bus.HREADYOUT && st < 1500) begin
         @(posedge HCLK); #1;
         st++;
      end
      check("stall_cycles", st, 1200);
      check("stall_rdata", bus.HRDATA, 32'h33);

      // CLEAR while busy is ignored; register write does not stall
      ahb_xfer(1'b1, 32'h2004, 32'h44, rd, st);
      ahb_xfer(1'b1, 32'h2004, 32'h55, rd, st);
      check("reg_nostall", st, 0);
      ahb_read_chk("clr_ignored", 32'h0154, 32'h44);

      // reset in the middle of a fill with a stalled read and display traffic
      mon_en = 1'b0;
      ahb_xfer(1'b1, 32'h2004, 32'h11, rd, st);
      addr_phase(1'b0, 32'h0000);
      @(posedge HCLK); #1;
      bus_idle();
      disp_req = 1'b1; disp_row = '0; disp_col = '0;
      repeat (50) @(posedge HCLK);
      #1;
      check("pre_rst_stall", 32'(bus.HREADYOUT), 32'h0);
      check("pre_rst_vld", 32'(disp_vld), 32'h1);
      HRESETn = 1'b0;
      #1;
      check("midfill_rst_hready", 32'(bus.HREADYOUT), 32'h1);
      check("midfill_rst_vld", 32'(disp_vld), 32'h0);
      check("midfill_rst_hrdata", bus.HRDATA, 32'h0);
      disp_req = 1'b0;
      dq.delete();
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      scroll_m = 0;
      mon_en = 1'b1;
      ahb_read_chk("rst_status", 32'h2008, 32'h0);
      ahb_read_chk("rst_scroll", 32'h2000, 32'h0);
      clear_poll(32'h66, nb, first, last);
      check("clr2_busy_first", 32'(first), 32'h1);
      check("clr2_busy_cycles", nb, 1200);
      for (int i = 0; i < CELLS; i++) ref_mem[i] = 8'h66;
      ahb_read_chk("clr2_cell0", 32'h0000, 32'h66);
      ahb_read_chk("clr2_cell85", 32'h0154, 32'h66);
      ahb_read_chk("clr2_last", 32'h12BC, 32'h66);
      disp_burst('{0, 29}, '{0, 39});
`else
      // CLEAR reserved: write ignored, reads 0, no stalls
      ahb_xfer(1'b1, 32'h2004, 32'h20, rd, st);
      check("clr_rsvd_nostall", st, 0);
      ahb_read_chk("clr_rsvd_read", 32'h2004, 32'h0);
      ahb_read_chk("status_idle", 32'h2008, 32'h0);
      ahb_xfer(1'b0, 32'h0000, 32'h0, rd, st);
      check("cell_nostall", st, 0);
      check("cell_not_cleared", rd, 32'h99);

      // async reset with display traffic in flight
      mon_en = 1'b0;
      @(posedge HCLK); #1;
      disp_req = 1'b1; disp_row = '0; disp_col = '0;
      repeat (3) @(posedge HCLK);
      #1;
      check("pre_rst_vld", 32'(disp_vld), 32'h1);
      HRESETn = 1'b0;
      #1;
      check("rst_vld", 32'(disp_vld), 32'h0);
      check("rst_char", 32'(disp_char), 32'h0);
      check("rst_hready", 32'(bus.HREADYOUT), 32'h1);
      disp_req = 1'b0;
      dq.delete();
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      scroll_m = 0;
      mon_en = 1'b1;
      ahb_read_chk("rst_scroll", 32'h2000, 32'h0);
      ahb_read_chk("ram_kept", 32'h0154, 32'h41);
      disp_burst('{2}, '{5});
`endif

      check("disp_drain", dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
